axi_lite_ram_bridge: RTL and testbench

AXI4-Lite slave that turns AW/W/B/AR/R channel handshakes into single-port RAM accesses. It sits between the AXI-Lite interface and one port of the dual-port RAM. It replaces ad-hoc direct wiring of AXI valid signals to RAM enables with a proper transaction FSM. It serves one transaction at a time, with an AXI-compliant response and error handling.

---
 rtl/axi_lite_pkg.sv | 27 ++
 rtl/axi_lite_ram_bridge.sv | 197 +++++++++++++++++++
 tb/tb_axi_lite_ram_bridge.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite to single-port RAM bridge.
//   - AXI response codes used on BRESP/RRESP
//   - bridge_state_e: transaction FSM states
//   - addr_in_range(): true when no address bit at or above hi_lsb is set
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_ACCEPT = 3'd1,
    ST_WR_EXEC   = 3'd2,
    ST_WR_RESP   = 3'd3,
    ST_RD_ACCEPT = 3'd4,
    ST_RD_EXEC   = 3'd5,
    ST_RD_WAIT   = 3'd6,
    ST_RD_RESP   = 3'd7
  } bridge_state_e;

  // hi_lsb is the first byte-address bit above the RAM word index.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input int unsigned hi_lsb);
    return (addr >> hi_lsb) == 64'd0;
  endfunction

endpackage

// File: rtl/axi_lite_ram_bridge.sv
// AXI4-Lite slave that serialises AW/W/B and AR/R transactions onto one
// single-port RAM port, one transaction at a time.
//
// Ports:
//   aclk, areset         clock, asynchronous active-high reset
//   s_aw*/s_w*/s_b*      AXI4-Lite write address, write data, write response
//   s_ar*/s_r*           AXI4-Lite read address, read data
//   ram_en/ram_we/ram_be RAM port controls (one-cycle strobe per access)
//   ram_addr/ram_wdata   RAM word address and write data
//   ram_rdata            RAM read data, valid one cycle after a read enable
//
// Handshakes: a transfer happens on the rising edge where valid and ready are
// both high; a valid, once raised, holds its payload stable until that edge.
//
// The FSM state is held in state_q for checkers to observe.
module axi_lite_ram_bridge
  import axi_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [DATA_WIDTH-1:0]     s_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [1:0]                s_bresp,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  output logic [DATA_WIDTH-1:0]     s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [DATA_WIDTH/8-1:0]   ram_be,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wdata,
  input  logic [DATA_WIDTH-1:0]     ram_rdata
);

  localparam int          STRB_W   = DATA_WIDTH / 8;
  localparam int          BYTE_LSB = (DATA_WIDTH == 64) ? 3 : 2;
  localparam int unsigned HI_LSB   = ADDR_WIDTH + BYTE_LSB;

  bridge_state_e           state_q, state_d;
  logic                    prio_wr_q, prio_wr_d;   // 1: next conflict goes to the write
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;         // shared by read and write paths
  logic                    err_q, err_d;           // captured address was out of range
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    awready_c, wready_c, arready_c;
  logic                    bvalid_c, rvalid_c;
  logic                    ram_en_c, ram_we_c;
  logic [STRB_W-1:0]       ram_be_c;
  logic                    aw_hs, w_hs;

  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    addr_d    = addr_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    rdata_d   = rdata_q;
    awready_c = 1'b0;
    wready_c  = 1'b0;
    arready_c = 1'b0;
    bvalid_c  = 1'b0;
    rvalid_c  = 1'b0;
    ram_en_c  = 1'b0;
    ram_we_c  = 1'b0;
    ram_be_c  = '0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A lone W beat counts as a pending write so it is not starved by reads.
        if ((s_awvalid || s_wvalid) && s_arvalid) begin
          state_d   = prio_wr_q ? ST_WR_ACCEPT : ST_RD_ACCEPT;
          prio_wr_d = ~prio_wr_q;
        end else if (s_awvalid || s_wvalid) begin
          state_d = ST_WR_ACCEPT;
        end else if (s_arvalid) begin
          state_d = ST_RD_ACCEPT;
        end
      end
      ST_WR_ACCEPT: begin
        awready_c = ~aw_held_q;
        wready_c  = ~w_held_q;
        aw_hs     = awready_c & s_awvalid;
        w_hs      = wready_c & s_wvalid;
        if (aw_hs) begin
          addr_d    = s_awaddr[HI_LSB-1:BYTE_LSB];
          err_d     = ~addr_in_range(64'(s_awaddr), HI_LSB);
          aw_held_d = 1'b1;
        end
        if (w_hs) begin
          wdata_d  = s_wdata;
          wstrb_d  = s_wstrb;
          w_held_d = 1'b1;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          state_d   = ST_WR_EXEC;
        end
      end
      ST_WR_EXEC: begin
        ram_en_c = ~err_q;
        ram_we_c = ~err_q;
        ram_be_c = err_q ? '0 : wstrb_q;
        state_d  = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        bvalid_c = 1'b1;
        if (s_bready) state_d = ST_IDLE;
      end
      ST_RD_ACCEPT: begin
        arready_c = 1'b1;
        if (s_arvalid) begin
          addr_d  = s_araddr[HI_LSB-1:BYTE_LSB];
          err_d   = ~addr_in_range(64'(s_araddr), HI_LSB);
          state_d = ST_RD_EXEC;
        end
      end
      ST_RD_EXEC: begin
        ram_en_c = ~err_q;
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // RAM data arrives this cycle; out-of-range reads never touched the RAM.
        rdata_d = err_q ? '0 : ram_rdata;
        state_d = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        rvalid_c = 1'b1;
        if (s_rready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      prio_wr_q <= 1'b1;
      addr_q    <= '0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_awready = awready_c;
  assign s_wready  = wready_c;
  assign s_arready = arready_c;
  assign s_bvalid  = bvalid_c;
  assign s_rvalid  = rvalid_c;
  assign s_bresp   = (bvalid_c && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign s_rresp   = (rvalid_c && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign s_rdata   = rdata_q;
  assign ram_en    = ram_en_c;
  assign ram_we    = ram_we_c;
  assign ram_be    = ram_be_c;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_axi_lite_ram_bridge.sv
// Testbench for axi_lite_ram_bridge: directed scenarios plus randomized
// transactions, checked by a scoreboard against a word-array reference model.
module tb_axi_lite_ram_bridge;

  localparam int AW = 32;
  localparam int A  = 10;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam logic [31:0] RANGE_BYTES = 32'(4 * (1 << A));

  // ---------------- clock / reset ----------------
  logic aclk;
  logic areset;
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic [AW-1:0] s_awaddr, s_araddr;
  logic          s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic [DW-1:0] s_wdata, s_rdata, ram_wdata, ram_rdata;
  logic [SW-1:0] s_wstrb, ram_be;
  logic [1:0]    s_bresp, s_rresp;
  logic          ram_en, ram_we;
  logic [A-1:0]  ram_addr;

  axi_lite_ram_bridge #(.AXI_ADDR_WIDTH(AW), .ADDR_WIDTH(A), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .areset(areset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // RAM attached to the bridge (environment, one-cycle read latency)
  logic [DW-1:0] ram_mem [0:(1<<A)-1];
  always @(posedge aclk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < SW; b++)
          if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= ram_mem[ram_addr];
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [1:0]    exp_b_q[$];
  logic [33:0]   exp_r_q[$];          // {rresp, rdata}
  logic [DW-1:0] ref_mem [0:(1<<A)-1];
  bit            model_prio_wr = 1'b1;
  int            exp_en = 0;
  int            ram_en_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    if (addr < RANGE_BYTES) begin
      for (int b = 0; b < SW; b++)
        if (strb[b]) ref_mem[addr / 4][8*b +: 8] = data[8*b +: 8];
      exp_b_q.push_back(2'b00);
      exp_en++;
    end else begin
      exp_b_q.push_back(2'b10);
    end
  endtask

  task automatic model_read(input logic [31:0] addr);
    if (addr < RANGE_BYTES) begin
      exp_r_q.push_back({2'b00, ref_mem[addr / 4]});
      exp_en++;
    end else begin
      exp_r_q.push_back({2'b10, 32'h0});
    end
  endtask

  // ---------------- monitor ----------------
  logic [1:0]  eb;
  logic [33:0] er;
  bit          b_stall = 0, r_stall = 0;
  logic [1:0]  b_prev;
  logic [33:0] r_prev;

  initial begin
    forever begin
      @(negedge aclk);
      if (areset) begin
        b_stall = 0;
        r_stall = 0;
      end else begin
        if (ram_en) ram_en_seen++;
        if (b_stall) check("b_stable", {s_bvalid, s_bresp}, {1'b1, b_prev});
        if (r_stall) check("r_stable", {s_rvalid, s_rresp, s_rdata}, {1'b1, r_prev});
        if (s_bvalid || s_rvalid)
          check("no_accept_while_busy", {s_awready, s_wready, s_arready}, 3'b000);
        if (s_bvalid && s_bready) begin
          if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
          else begin
            eb = exp_b_q.pop_front();
            check("bresp", s_bresp, eb);
          end
        end
        if (s_rvalid && s_rready) begin
          if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
          else begin
            er = exp_r_q.pop_front();
            check("rdata", s_rdata, er[31:0]);
            check("rresp", s_rresp, er[33:32]);
          end
        end
        b_stall = s_bvalid && !s_bready;
        b_prev  = s_bresp;
        r_stall = s_rvalid && !s_rready;
        r_prev  = {s_rresp, s_rdata};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
                            ram_en, ram_we, ram_be, s_bresp, s_rresp}, '0);
    check({name, "_data"}, {s_rdata, ram_addr, ram_wdata}, '0);
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    areset = 1;
    @(posedge aclk); #1;
    areset = 0;
    model_prio_wr = 1'b1;
  endtask

  task automatic run_txn(input bit do_wr, input bit do_rd,
                         input logic [31:0] waddr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] raddr,
                         input int aw_start, input int w_start,
                         input int b_delay, input int r_delay,
                         output int b_lat, output int r_lat, output int en_lat,
                         output bit wr_first_seen, output bit exp_wr_first);
    bit aw_done = 0, w_done = 0, ar_done = 0, b_done = 0, r_done = 0, grant_seen = 0;
    int b_wait = 0, r_wait = 0;
    exp_wr_first = do_wr;
    if (do_wr && do_rd) begin
      exp_wr_first  = model_prio_wr;
      model_prio_wr = !model_prio_wr;
    end
    if (exp_wr_first) begin
      if (do_wr) model_write(waddr, wdata, wstrb);
      if (do_rd) model_read(raddr);
    end else begin
      if (do_rd) model_read(raddr);
      if (do_wr) model_write(waddr, wdata, wstrb);
    end
    b_lat = -1; r_lat = -1; en_lat = -1; wr_first_seen = 0;
    s_awaddr = waddr; s_wdata = wdata; s_wstrb = wstrb; s_araddr = raddr;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if ((!do_wr || b_done) && (!do_rd || r_done)) break;
      s_awvalid = do_wr && !aw_done && (cyc >= aw_start);
      s_wvalid  = do_wr && !w_done && (cyc >= w_start);
      s_arvalid = do_rd && !ar_done;
      s_bready  = (b_wait >= b_delay);
      s_rready  = (r_wait >= r_delay);
      @(negedge aclk);
      if (!grant_seen && (s_awready || s_wready || s_arready)) begin
        grant_seen    = 1;
        wr_first_seen = s_awready || s_wready;
      end
      if (s_awvalid && s_awready) aw_done = 1;
      if (s_wvalid && s_wready) w_done = 1;
      if (s_arvalid && s_arready) ar_done = 1;
      if (ram_en && en_lat < 0) en_lat = cyc;
      if (s_bvalid) begin
        if (b_lat < 0) b_lat = cyc;
        if (s_bready) b_done = 1; else b_wait++;
      end
      if (s_rvalid) begin
        if (r_lat < 0) r_lat = cyc;
        if (s_rready) r_done = 1; else r_wait++;
      end
      @(posedge aclk); #1;
    end
    idle_inputs();
    if (!((!do_wr || b_done) && (!do_rd || r_done))) check("txn_timeout", 0, 1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 7) == 0)
      a = (32'h1000 << $urandom_range(0, 19)) | 32'($urandom_range(0, 4095));
    else
      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
    return a;
  endfunction

  // ---------------- main stimulus ----------------
  int  bl, rl, el, en_before, rv_cnt, kind;
  bit  wfs, ewf, seen, ar_hs;

  initial begin
    areset = 1;
    s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
    idle_inputs();
    @(posedge aclk); @(posedge aclk);
    @(negedge aclk);
    check_all_zero("reset");
    @(posedge aclk); #1;
    areset = 0;

    // known contents for words 0..15
    for (int w = 0; w < 16; w++)
      run_txn(1, 0, 32'(w * 4), $urandom, 4'hF, 0, 0, 0, 0, 0, bl, rl, el, wfs, ewf);

    // basic write then read with latency
    run_txn(1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, bl, rl, el, wfs, ewf);
    check("wr_ram_cycle", el, 2);
    check("bvalid_cycle", bl, 3);
    run_txn(0, 1, 0, 0, 0, 32'h10, 0, 0, 0, 0, bl, rl, el, wfs, ewf);
    check("rd_ram_cycle", el, 2);
    check("rvalid_cycle", rl, 4);

    // W two cycles before AW, partial strobe
    run_txn(1, 0, 32'h14, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 0, bl, rl, el, wfs, ewf);
    run_txn(1, 0, 32'h14, 32'h00001234, 4'h3, 0, 2, 0, 0, 0, bl, rl, el, wfs, ewf);
    run_txn(0, 1, 0, 0, 0, 32'h14, 0, 0, 0, 0, bl, rl, el, wfs, ewf);

    // zero strobe leaves the word alone
    run_txn(1, 0, 32'h18, 32'h55AA55AA, 4'h0, 0, 0, 0, 0, 0, bl, rl, el, wfs, ewf);
    run_txn(0, 1, 0, 0, 0, 32'h18, 0, 0, 0, 0, bl, rl, el, wfs, ewf);

    // out of range: SLVERR and no RAM access
    en_before = ram_en_seen;
    run_txn(1, 0, 32'h1000, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, 0, bl, rl, el, wfs, ewf);
    run_txn(0, 1, 0, 0, 0, 32'h1000, 0, 0, 0, 0, bl, rl, el, wfs, ewf);
    check("oor_no_ram_en", ram_en_seen - en_before, 0);

    // arbitration after reset: write first, then read
    do_reset();
    run_txn(1, 1, 32'h20, 32'h11112222, 4'hF, 32'h20, 0, 0, 0, 0, bl, rl, el, wfs, ewf);
    check("grant_first_conflict", wfs, ewf);
    run_txn(1, 1, 32'h20, 32'h33334444, 4'hF, 32'h20, 0, 0, 0, 0, bl, rl, el, wfs, ewf);
    check("grant_second_conflict", wfs, ewf);

    // response back-pressure
    run_txn(1, 0, 32'h24, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 5, 0, bl, rl, el, wfs, ewf);
    run_txn(0, 1, 0, 0, 0, 32'h24, 0, 0, 0, 5, bl, rl, el, wfs, ewf);

    // reset while the read data is in flight
    s_araddr = 32'h8; s_arvalid = 1; seen = 0; ar_hs = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge aclk);
      if (s_arvalid && s_arready) ar_hs = 1;
      if (ram_en) seen = 1;
      @(posedge aclk); #1;
      if (ar_hs) s_arvalid = 0;
    end
    if (!seen) check("rst_read_timeout", 0, 1);
    exp_en++;
    areset = 1;
    #1;
    check_all_zero("reset_mid_read");
    model_prio_wr = 1'b1;
    s_arvalid = 0;
    @(posedge aclk); #1;
    areset = 0;
    rv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      if (s_rvalid) rv_cnt++;
    end
    check("no_rvalid_after_reset", rv_cnt, 0);
    @(posedge aclk); #1;
    run_txn(0, 1, 0, 0, 0, 32'h8, 0, 0, 0, 0, bl, rl, el, wfs, ewf);
    check("post_reset_rvalid_cycle", rl, 4);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0)
        run_txn(1, 0, rand_addr(), $urandom, 4'($urandom_range(0, 15)), 0,
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), 0,
                bl, rl, el, wfs, ewf);
      else if (kind == 1)
        run_txn(0, 1, 0, 0, 0, rand_addr(), 0, 0, 0, $urandom_range(0, 3),
                bl, rl, el, wfs, ewf);
      else begin
        run_txn(1, 1, rand_addr(), $urandom, 4'($urandom_range(0, 15)), rand_addr(),
                0, 0, $urandom_range(0, 3), $urandom_range(0, 3), bl, rl, el, wfs, ewf);
        check("grant_random_conflict", wfs, ewf);
      end
    end

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("ram_en_cycles", ram_en_seen, exp_en);
    check("b_queue_drained", exp_b_q.size(), 0);
    check("r_queue_drained", exp_r_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
